// File: rtl/fast_to_slow_sender_if.sv
// Bundle of the event, handshake and status signals of the fast-to-slow sender.
// Ports: pulse_in/ovf_clr (event side), ack_async/req (crossing pair),
//        busy/done/pending/overflow (status); PEND_W sizes the pending count.
interface fast_to_slow_sender_if #(
  parameter int PEND_W = 4
);
  logic              pulse_in;
  logic              ack_async;
  logic              ovf_clr;
  logic              req;
  logic              busy;
  logic              done;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  // Source of events and responder side: drives inputs, observes outputs.
  modport master (
    output pulse_in, ack_async, ovf_clr,
    input  req, busy, done, pending, overflow
  );

  // The sender itself.
  modport slave (
    input  pulse_in, ack_async, ovf_clr,
    output req, busy, done, pending, overflow
  );
endinterface

// File: rtl/fast_to_slow_sender.sv
// Purpose: fast-domain sender turning pulse_in strobes into a 4-phase req/ack
//          handshake; events arriving mid-handshake are held in a saturating count.
// Latency: pulse_in in IDLE gives req=1 one edge later; ack_async reaches the FSM
//          after SYNC_STAGES edges. Backpressure: none on pulse_in; events beyond
//          PEND_MAX queued are dropped and flagged in sticky overflow.
// Ports: clk, n_rst (sync, active-low), bus (slave modport of fast_to_slow_sender_if).
module fast_to_slow_sender #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  fast_to_slow_sender_if.slave bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic [PEND_W-1:0]      pending_q, pending_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;

  logic                   ack_sync;
  logic                   avail;
  logic                   launch;
  logic                   ovf_set;
  logic [PEND_W:0]        pend_sum;

  // Synchronizer: bit 0 samples the asynchronous ack, the top bit feeds the FSM.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_async};
    end
  end

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  assign avail    = (pending_q != '0) | bus.pulse_in;

  // Next-state, launch and done decode.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A still-high ack belongs to an abandoned handshake; wait it out.
        if (avail && !ack_sync) begin
          launch  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_sync) begin
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!ack_sync) begin
          done_d = 1'b1;
          // Chain straight into the next handshake when work is waiting.
          if (avail) begin
            launch  = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // req is high exactly while a handshake is in its request phase.
  assign req_d = (state_d == REQ);

  // Pending update is computed one bit wider so the saturation case is explicit.
  // launch never fires with pending==0 and no pulse, so no underflow is possible.
  always_comb begin
    pend_sum   = {1'b0, pending_q}
               + {{PEND_W{1'b0}}, bus.pulse_in}
               - {{PEND_W{1'b0}}, launch};
    ovf_set    = bus.pulse_in && (pending_q == PEND_MAX) && !launch;
    pending_d  = ovf_set ? PEND_MAX : pend_sum[PEND_W-1:0];
    // A drop in the same cycle as a clear must still be reported.
    overflow_d = ovf_set | (overflow_q & ~bus.ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      done_q     <= done_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.req      = req_q;
  assign bus.done     = done_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_fast_to_slow_sender.sv
// Bench for fast_to_slow_sender: a PEND_W=4 instance with a responder model and a
// PEND_W=2 instance used for saturation; done strobes are scored against a queue.
// Handshake completions are pushed as they are driven and popped on each done.
module tb_fast_to_slow_sender;

  localparam int SYNC_STAGES = 2;

  logic clk;
  logic n_rst;

  fast_to_slow_sender_if #(.PEND_W(4)) ifa ();
  fast_to_slow_sender_if #(.PEND_W(2)) ifb ();

  fast_to_slow_sender #(.SYNC_STAGES(SYNC_STAGES), .PEND_W(4)) dut_a (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (ifa)
  );

  fast_to_slow_sender #(.SYNC_STAGES(SYNC_STAGES), .PEND_W(2)) dut_b (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int done_cnt;
  int sb_seq;
  int sb_q[$];

  logic resp_en;
  logic resp_ack;
  logic ack_man;
  int   rcnt;

  assign ifa.ack_async = resp_en ? resp_ack : ack_man;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sb_push();
    sb_seq++;
    sb_q.push_back(sb_seq);
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ifa.done) begin
        done_cnt++;
        if (sb_q.size() == 0) check("sb_unexpected_done", done_cnt, 0);
        else                  check("sb_done_seq", done_cnt, sb_q.pop_front());
      end
    end
  endtask

  task automatic wait_idle_a(input string tag);
    int c;
    c = 0;
    while (ifa.busy && c < 200) begin
      tick(1);
      c++;
    end
    if (ifa.busy) check(tag, 1, 0);
  endtask

  // Slow-side responder: follows req with a 3-cycle lag in both directions.
  initial begin
    resp_ack = 1'b0;
    rcnt     = 0;
    forever begin
      @(negedge clk);
      if (!resp_en || (ifa.req == resp_ack)) begin
        rcnt = 0;
      end else begin
        rcnt++;
        if (rcnt == 3) begin
          resp_ack = ifa.req;
          rcnt     = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   d0, ack_i, fall_i, dn, rises;
    logic prev_req;

    n_checks = 0; n_errors = 0; done_cnt = 0; sb_seq = 0;
    resp_en = 1'b0; ack_man = 1'b0;
    n_rst = 1'b0;
    ifa.pulse_in = 1'b0; ifa.ovf_clr = 1'b0;
    ifb.pulse_in = 1'b0; ifb.ovf_clr = 1'b0; ifb.ack_async = 1'b0;
    tick(3);

    // Reset state
    check("rst_req", ifa.req, 0);
    check("rst_done", ifa.done, 0);
    check("rst_pending", ifa.pending, 0);
    check("rst_overflow", ifa.overflow, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_b_overflow", ifb.overflow, 0);
    n_rst = 1'b1;
    tick(3);

    // Single event
    resp_en = 1'b1;
    d0 = done_cnt;
    ifa.pulse_in = 1'b1;
    sb_push();
    tick(1);
    ifa.pulse_in = 1'b0;
    check("single_req_rise", ifa.req, 1);
    check("single_pending", ifa.pending, 0);
    ack_i = -1; fall_i = -1;
    for (int c = 1; c <= 60 && fall_i < 0; c++) begin
      tick(1);
      check("single_pending_hold", ifa.pending, 0);
      if (ack_i < 0 && ifa.ack_async) ack_i = c;
      if (!ifa.req) fall_i = c;
    end
    check("single_req_fall_lat", fall_i - ack_i, SYNC_STAGES);
    wait_idle_a("single_timeout");
    tick(4);
    check("single_done_cnt", done_cnt - d0, 1);
    check("single_sb_empty", sb_q.size(), 0);

    // Burst of 5 while idle
    d0 = done_cnt;
    ifa.pulse_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sb_push();
      tick(1);
      check("burst_pending", ifa.pending, i - 1);
    end
    ifa.pulse_in = 1'b0;
    check("burst_req", ifa.req, 1);
    dn = 0; rises = 0; prev_req = ifa.req;
    for (int c = 0; c < 400 && dn < 5; c++) begin
      tick(1);
      if (ifa.req && !prev_req) rises++;
      prev_req = ifa.req;
      if (ifa.done) begin
        dn++;
        // Back-to-back: the next req rises on the same edge as done.
        check("burst_b2b_req", ifa.req, (dn < 5) ? 1 : 0);
      end
    end
    check("burst_dones", dn, 5);
    check("burst_relaunches", rises, 4);
    check("burst_busy_end", ifa.busy, 0);
    check("burst_pending_end", ifa.pending, 0);
    check("burst_overflow", ifa.overflow, 0);
    tick(4);
    check("burst_sb_empty", sb_q.size(), 0);

    // Pulse coinciding with WAIT_LOW seeing ack low, pending=2
    resp_en = 1'b0;
    ack_man = 1'b0;
    d0 = done_cnt;
    ifa.pulse_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_push();
      tick(1);
    end
    ifa.pulse_in = 1'b0;
    check("sim_pending_pre", ifa.pending, 2);
    ack_man = 1'b1;
    tick(SYNC_STAGES + 1);
    check("sim_req_low", ifa.req, 0);
    ack_man = 1'b0;
    tick(SYNC_STAGES);
    check("sim_wait_low_req", ifa.req, 0);
    check("sim_wait_low_pending", ifa.pending, 2);
    ifa.pulse_in = 1'b1;
    sb_push();
    tick(1);
    ifa.pulse_in = 1'b0;
    check("sim_req", ifa.req, 1);
    check("sim_pending", ifa.pending, 2);
    check("sim_done", ifa.done, 1);
    resp_en = 1'b1;
    wait_idle_a("sim_timeout");
    tick(4);
    check("sim_done_cnt", done_cnt - d0, 4);
    check("sim_sb_empty", sb_q.size(), 0);

    // Overflow on the PEND_W=2 instance with ack withheld
    ifb.pulse_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check("ovf_pending", ifb.pending, (i - 1 < 3) ? i - 1 : 3);
      check("ovf_flag", ifb.overflow, (i >= 5) ? 1 : 0);
    end
    check("ovf_req", ifb.req, 1);
    ifb.ovf_clr = 1'b1;
    tick(1);
    check("ovf_clr_vs_set", ifb.overflow, 1);
    check("ovf_clr_vs_set_pend", ifb.pending, 3);
    ifb.pulse_in = 1'b0;
    tick(1);
    check("ovf_cleared", ifb.overflow, 0);
    ifb.ovf_clr = 1'b0;
    tick(1);
    check("ovf_stays_clear", ifb.overflow, 0);
    check("ovf_b_done", ifb.done, 0);

    // Stale ack held through reset
    resp_en = 1'b0;
    ack_man = 1'b1;
    n_rst = 1'b0;
    tick(3);
    check("stale_rst_req", ifa.req, 0);
    check("stale_rst_pending", ifa.pending, 0);
    n_rst = 1'b1;
    tick(SYNC_STAGES + 2);
    ifa.pulse_in = 1'b1;
    tick(1);
    ifa.pulse_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stale_hold_req", ifa.req, 0);
      check("stale_hold_pending", ifa.pending, 1);
      tick(1);
    end
    ack_man = 1'b0;
    for (int i = 1; i <= SYNC_STAGES + 1; i++) begin
      tick(1);
      check("stale_release_req", ifa.req, (i == SYNC_STAGES + 1) ? 1 : 0);
    end
    check("stale_release_pending", ifa.pending, 0);

    // Reset while in REQ with pending=3
    ifa.pulse_in = 1'b1;
    tick(3);
    ifa.pulse_in = 1'b0;
    check("midrst_pre_pending", ifa.pending, 3);
    check("midrst_pre_req", ifa.req, 1);
    n_rst = 1'b0;
    tick(1);
    check("midrst_req", ifa.req, 0);
    check("midrst_pending", ifa.pending, 0);
    check("midrst_busy", ifa.busy, 0);
    n_rst = 1'b1;
    tick(SYNC_STAGES + 2);
    check("midrst_after_req", ifa.req, 0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
